// File: rtl/iddmm_pkg.sv
// rtl/iddmm_pkg.sv - shared widths, latency default and REDC state encoding
package iddmm_pkg;
  localparam int WORD            = 128;
  localparam int DEFAULT_MUL_LAT = 8;

  typedef enum logic [2:0] {IDLE, MUL_M, MUL_MN, ADD, FIN, OUT} redc_state_t;

  typedef logic [WORD-1:0]   word_t;
  typedef logic [2*WORD-1:0] dword_t;
endpackage

// File: rtl/iddmm_cond_sub.sv
// rtl/iddmm_cond_sub.sv - registered final correction of u < 2N into [0, N)
module iddmm_cond_sub
  import iddmm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [WORD:0] u,
  input  word_t         n,
  output word_t         result
);
  logic [WORD:0] diff;

  assign diff = u - {1'b0, n};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
    end else if (en) begin
      result <= (u >= {1'b0, n}) ? diff[WORD-1:0] : u[WORD-1:0];
    end
  end
endmodule

// File: rtl/iddmm_mul_128_to_128.sv
// rtl/iddmm_mul_128_to_128.sv - pipelined low-half multiplier, x*y mod 2^WORD
// Operands must stay stable for LAT cycles; the product is valid in the LAT-th cycle.
module iddmm_mul_128_to_128
  import iddmm_pkg::*;
#(
  parameter int LAT = DEFAULT_MUL_LAT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  word_t x,
  input  word_t y,
  output word_t p
);
  word_t pipe [LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= x * y;
      for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LAT-2];
endmodule

// File: rtl/iddmm_mul_128_to_256.sv
// rtl/iddmm_mul_128_to_256.sv - pipelined full-width multiplier, x*y
// Operands must stay stable for LAT cycles; the product is valid in the LAT-th cycle.
module iddmm_mul_128_to_256
  import iddmm_pkg::*;
#(
  parameter int LAT = DEFAULT_MUL_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  word_t  x,
  input  word_t  y,
  output dword_t p
);
  dword_t pipe [LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dword_t'(x) * dword_t'(y);
      for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LAT-2];
endmodule

// File: rtl/iddmm_redc_128.sv
// rtl/iddmm_redc_128.sv - Montgomery REDC: T*2^-128 mod N, one operation at a time
module iddmm_redc_128
  import iddmm_pkg::*;
#(
  parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  dword_t t,
  input  word_t  n,
  input  word_t  n_prime,
  output logic   out_valid,
  input  logic   out_ready,
  output word_t  result
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  redc_state_t   state;
  logic [CW-1:0] cnt;
  dword_t        t_q;
  word_t         n_q;
  word_t         np_q;
  word_t         m_q;
  dword_t        mn_q;
  logic [WORD:0] u_q;
  word_t         m_w;
  dword_t        mn_w;
  logic [2*WORD:0] s;
  logic          last;

  // Both multipliers read latched registers directly, so operands hold for the whole state.
  iddmm_mul_128_to_128 #(.LAT(MUL_LAT)) u_mul_m (
    .clk(clk), .rst_n(rst_n), .x(t_q[WORD-1:0]), .y(np_q), .p(m_w)
  );

  iddmm_mul_128_to_256 #(.LAT(MUL_LAT)) u_mul_mn (
    .clk(clk), .rst_n(rst_n), .x(m_q), .y(n_q), .p(mn_w)
  );

  iddmm_cond_sub u_cond_sub (
    .clk(clk), .rst_n(rst_n), .en(state == FIN), .u(u_q), .n(n_q), .result(result)
  );

  assign in_ready = (state == IDLE);
  assign last     = (cnt == CW'(MUL_LAT - 1));
  // Low half of s is zero by construction of m; only the upper 129 bits matter.
  assign s        = {1'b0, t_q} + {1'b0, mn_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      t_q       <= '0;
      n_q       <= '0;
      np_q      <= '0;
      m_q       <= '0;
      mn_q      <= '0;
      u_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t_q   <= t;
            n_q   <= n;
            np_q  <= n_prime;
            cnt   <= '0;
            state <= MUL_M;
          end
        end
        MUL_M: begin
          if (last) begin
            m_q   <= m_w;
            cnt   <= '0;
            state <= MUL_MN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL_MN: begin
          if (last) begin
            mn_q  <= mn_w;
            cnt   <= '0;
            state <= ADD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADD: begin
          u_q   <= s[2*WORD:WORD];
          state <= FIN;
        end
        FIN: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iddmm_redc_128.sv
// tb/tb_iddmm_redc_128.sv - randomized self-checking bench for iddmm_redc_128
module tb_iddmm_redc_128;
  import iddmm_pkg::*;

  localparam int ML  = DEFAULT_MUL_LAT;
  localparam int LAT = 2*ML + 2;
  // Each operation occupies IDLE + MUL_M + MUL_MN + ADD + FIN + OUT cycles.
  localparam int GAP = 2*ML + 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  dword_t t = '0;
  word_t  n = '0;
  word_t  n_prime = '0;
  logic   out_valid;
  logic   out_ready = 1'b1;
  word_t  result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iddmm_redc_128 #(.MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .t(t), .n(n), .n_prime(n_prime), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : s_mon
    word_t lo;
    if (rst_n && dut.state == ADD) begin
      lo = dut.t_q[WORD-1:0] + dut.mn_q[WORD-1:0];
      check("s_lo", {256'b0, lo}, '0);
    end
  end

  function automatic word_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // -N^-1 mod 2^128 by Newton iteration; each step doubles the correct low bits.
  function automatic word_t nprime_of(input word_t nn);
    word_t inv, two, zero;
    inv  = nn;
    two  = word_t'(2);
    zero = '0;
    for (int i = 0; i < 7; i++) inv = inv * (two - nn * inv);
    return zero - inv;
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 384'd0, 384'd1);
  endtask

  task automatic start(input dword_t tt, input word_t nn, input word_t np);
    wait_ready();
    t = tt; n = nn; n_prime = np; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op(output word_t r, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) busy_ok = 1'b0;
    end
    if (!out_valid) check("out_valid_timeout", 384'd0, 384'd1);
    r = result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input dword_t tt, input word_t nn, input word_t np, output word_t r);
    int lat;
    bit busy_ok;
    start(tt, nn, np);
    finish_op(r, lat, busy_ok);
  endtask

  // r is T*R^-1 mod N exactly when r < N and r*R == T (mod N), R being invertible for odd N.
  task automatic check_model(input string tag, input dword_t tt, input word_t nn, input word_t r);
    logic [383:0] lhs, rhs, nw;
    nw  = {256'b0, nn};
    lhs = {128'b0, r, 128'b0} % nw;
    rhs = {128'b0, tt} % nw;
    check(tag, lhs, rhs);
    check({tag, "_range"}, {383'b0, (r < nn)}, 384'd1);
  endtask

  initial begin : main
    word_t  r, r0, nmax, n3, np3, nr, npr, e;
    dword_t tt;
    int     lat, acc_prev;
    bit     busy_ok, stable;
    dword_t bt [5];

    nmax = '1;
    n3   = word_t'(3);
    np3  = {32{4'h5}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {383'b0, in_ready}, 384'd1);
    check("rst_out_valid", {383'b0, out_valid}, 384'd0);
    check("rst_result", {256'b0, result}, 384'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start(dword_t'(0), nmax, word_t'(1));
    finish_op(r, lat, busy_ok);
    check("nmax_t0", {256'b0, r}, 384'd0);
    check("latency", lat, LAT);
    check("busy_in_ready", {383'b0, busy_ok}, 384'd1);

    do_op(dword_t'(1), nmax, word_t'(1), r);
    check("nmax_t1", {256'b0, r}, 384'd1);
    tt = {nmax, 128'b0} - 1'b1;
    e  = nmax - 1'b1;
    do_op(tt, nmax, word_t'(1), r);
    check("nmax_top", {256'b0, r}, {256'b0, e});

    do_op(dword_t'(5), n3, np3, r);
    check("n3_t5", {256'b0, r}, 384'd2);
    do_op(dword_t'(1), n3, np3, r);
    check("n3_t1", {256'b0, r}, 384'd1);

    for (int i = 0; i < 1000; i++) begin
      tt = {word_t'($urandom_range(2)), rnd128()};
      do_op(tt, n3, np3, r);
      check_model("n3_rand", tt, n3, r);
    end

    for (int i = 0; i < 20; i++) begin
      nr  = rnd128() | word_t'(1);
      npr = nprime_of(nr);
      tt  = {rnd128(), rnd128()} % {nr, 128'b0};
      do_op(tt, nr, npr, r);
      check_model("rand_n", tt, nr, r);
    end

    out_ready = 1'b0;
    start(dword_t'(5), n3, np3);
    finish_op(r0, lat, busy_ok);
    check("bp_result", {256'b0, r0}, 384'd2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        t = dword_t'(1); in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!out_valid || result !== r0 || in_ready) stable = 1'b0;
    end
    check("bp_hold", {383'b0, stable}, 384'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {383'b0, out_valid}, 384'd0);
    check("bp_release_ready", {383'b0, in_ready}, 384'd1);

    start(dword_t'(1), n3, np3);
    repeat (ML + 2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {383'b0, in_ready}, 384'd1);
    check("midrst_out_valid", {383'b0, out_valid}, 384'd0);
    check("midrst_result", {256'b0, result}, 384'd0);
    do_op(dword_t'(5), n3, np3, r);
    check("post_rst", {256'b0, r}, 384'd2);

    for (int k = 0; k < 5; k++) bt[k] = {word_t'($urandom_range(2)), rnd128()};
    acc_prev = 0;
    t = bt[0]; n = n3; n_prime = np3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      @(posedge clk); #1;
      if (k > 0) check("b2b_gap", cyc - acc_prev, GAP);
      acc_prev = cyc;
      if (k < 4) t = bt[k+1];
      else in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      check("b2b_latency", lat, LAT);
      check_model("b2b", bt[k], n3, result);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
